// File: rtl/core_pkg.sv
// Shared core types and constants used by the fetch queue and later pipeline buffers.
package core_pkg;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    localparam int         FETCH_QUEUE_DEPTH = 4;
    localparam logic [1:0] OPC_LEN32         = 2'b11;

endpackage

// File: rtl/core_fetch_queue_if.sv
// Fetch-to-decode queue bus: fetch push side, flush, decode handshake and status.
interface core_fetch_queue_if
    import core_pkg::*;
#(
    parameter int DEPTH = FETCH_QUEUE_DEPTH
);
    logic [31:0]              fetch_instr_i;
    logic                     fetch_valid_i;
    logic [31:0]              fetch_pc_i;
    logic                     fetch_stall_o;
    logic                     flush_i;
    logic [31:0]              dec_instr_o;
    logic [31:0]              dec_pc_o;
    logic                     dec_illegal_o;
    logic                     dec_valid_o;
    logic                     dec_ready_i;
    logic [$clog2(DEPTH):0]   count_o;
    logic                     overflow_o;

    modport master (
        output fetch_instr_i, fetch_valid_i, fetch_pc_i, flush_i, dec_ready_i,
        input  fetch_stall_o, dec_instr_o, dec_pc_o, dec_illegal_o, dec_valid_o,
        input  count_o, overflow_o
    );

    modport slave (
        input  fetch_instr_i, fetch_valid_i, fetch_pc_i, flush_i, dec_ready_i,
        output fetch_stall_o, dec_instr_o, dec_pc_o, dec_illegal_o, dec_valid_o,
        output count_o, overflow_o
    );
endinterface

// File: rtl/core_fifo_mem.sv
// Unreset register-array storage: one synchronous write port, one asynchronous read port.
module core_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk_i,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/core_fetch_queue.sv
// Fetch-to-decode circular queue; entries visible one cycle after push, no bypass.
// Stall asserts SKID entries early so fetch's one-cycle response never overruns.
module core_fetch_queue
    import core_pkg::*;
#(
    parameter int DEPTH = FETCH_QUEUE_DEPTH,
    parameter int SKID  = 1
) (
    input  logic              clk_i,
    input  logic              arst_i,
    core_fetch_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] STALL_CNT = CW'(DEPTH - SKID);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic          not_empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          drop;
    fetch_entry_t  wr_entry;
    fetch_entry_t  rd_entry;
    logic [$bits(fetch_entry_t)-1:0] rd_bits;

    assign not_empty = (count != '0);
    assign full      = (count == FULL_CNT);
    // Flush suppresses both sides; a pop frees the slot a full-queue push needs.
    assign pop       = not_empty & bus.dec_ready_i & ~bus.flush_i;
    assign push      = bus.fetch_valid_i & ~bus.flush_i & (~full | pop);
    assign drop      = bus.fetch_valid_i & ~bus.flush_i & ~push;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Sticky until reset; flush deliberately leaves it set.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i)    overflow <= 1'b0;
        else if (drop) overflow <= 1'b1;
    end

    assign wr_entry = '{instr: bus.fetch_instr_i, pc: bus.fetch_pc_i};

    core_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_mem (
        .clk_i (clk_i),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_bits)
    );

    assign rd_entry = fetch_entry_t'(rd_bits);

    assign bus.dec_valid_o   = not_empty;
    assign bus.dec_instr_o   = not_empty ? rd_entry.instr : '0;
    assign bus.dec_pc_o      = not_empty ? rd_entry.pc    : '0;
    assign bus.dec_illegal_o = not_empty & (rd_entry.instr[1:0] != OPC_LEN32);
    assign bus.fetch_stall_o = (count >= STALL_CNT);
    assign bus.count_o       = count;
    assign bus.overflow_o    = overflow;
endmodule

// File: tb/tb_core_fetch_queue.sv
// Self-checking bench for core_fetch_queue against a queue-based reference model.
module tb_core_fetch_queue;
    localparam int DEPTH = 4;
    localparam int SKID  = 1;

    logic clk = 1'b0;
    logic arst = 1'b1;
    int   vectors = 0;
    int   errors  = 0;

    // Reference model: ordered list of {instr, pc} plus sticky overflow.
    logic [63:0] model_q[$];
    bit          model_ovf = 1'b0;

    core_fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    core_fetch_queue #(.DEPTH(DEPTH), .SKID(SKID)) dut (
        .clk_i  (clk),
        .arst_i (arst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic cycle(input bit fv, input logic [31:0] ins, input logic [31:0] pc,
                         input bit fl, input bit rdy);
        bit m_pop;
        bit m_push;
        bus.fetch_valid_i = fv;
        bus.fetch_instr_i = ins;
        bus.fetch_pc_i    = pc;
        bus.flush_i       = fl;
        bus.dec_ready_i   = rdy;
        m_pop  = (model_q.size() != 0) && rdy && !fl;
        m_push = fv && !fl && ((model_q.size() < DEPTH) || m_pop);
        if (fv && !fl && !m_push) model_ovf = 1'b1;
        if (fl) model_q.delete();
        else begin
            if (m_pop)  void'(model_q.pop_front());
            if (m_push) model_q.push_back({ins, pc});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 arst = 1'b1;
        #3 arst = 1'b0;
        model_q.delete();
        model_ovf = 1'b0;
        bus.fetch_valid_i = 1'b0;
        bus.flush_i       = 1'b0;
        bus.dec_ready_i   = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.fetch_valid_i = 1'b0;
        bus.fetch_instr_i = '0;
        bus.fetch_pc_i    = '0;
        bus.flush_i       = 1'b0;
        bus.dec_ready_i   = 1'b0;
        arst = 1'b1;
        repeat (2) @(posedge clk);
        #2 arst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors += 5;
        if (bus.dec_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", bus.dec_valid_o); end
        if (bus.count_o !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.count_o); end
        if (bus.fetch_stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b want 0", bus.fetch_stall_o); end
        if (bus.overflow_o !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b want 0", bus.overflow_o); end
        if (bus.dec_instr_o !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", bus.dec_instr_o); end
    endtask

    task automatic test_single();
        do_reset();
        cycle(1, 32'h00500093, 32'h0, 0, 1);
        vectors += 4;
        if (bus.dec_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", bus.dec_valid_o); end
        if (bus.dec_instr_o !== 32'h00500093) begin errors++; $display("FAIL single_instr got %h want 00500093", bus.dec_instr_o); end
        if (bus.dec_pc_o !== 32'h0) begin errors++; $display("FAIL single_pc got %h want 0", bus.dec_pc_o); end
        if (bus.dec_illegal_o !== 1'b0) begin errors++; $display("FAIL single_illegal got %0b want 0", bus.dec_illegal_o); end
        cycle(0, 32'h0, 32'h0, 0, 1);
        vectors++;
        if (bus.count_o !== 3'd0) begin errors++; $display("FAIL single_count got %0d want 0", bus.count_o); end
    endtask

    task automatic test_fill_stall();
        logic [31:0] exp_pc;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (bus.fetch_stall_o !== 1'b0) begin errors++; $display("FAIL fill_early_stall i=%0d got %0b want 0", i, bus.fetch_stall_o); end
            cycle(1, 32'h00000013, 32'(i * 4), 0, 0);
        end
        vectors += 2;
        if (bus.count_o !== 3'd3) begin errors++; $display("FAIL fill_count3 got %0d want 3", bus.count_o); end
        if (bus.fetch_stall_o !== 1'b1) begin errors++; $display("FAIL fill_stall got %0b want 1", bus.fetch_stall_o); end
        cycle(1, 32'h00000013, 32'hC, 0, 0);
        vectors++;
        if (bus.count_o !== 3'd4) begin errors++; $display("FAIL fill_count4 got %0d want 4", bus.count_o); end
        cycle(1, 32'h00000013, 32'h10, 0, 0);
        vectors += 2;
        if (bus.count_o !== 3'd4) begin errors++; $display("FAIL drop_count got %0d want 4", bus.count_o); end
        if (bus.overflow_o !== 1'b1) begin errors++; $display("FAIL drop_ovf got %0b want 1", bus.overflow_o); end
        for (int i = 0; i < 4; i++) begin
            exp_pc = 32'(i * 4);
            vectors++;
            if (bus.dec_pc_o !== exp_pc) begin errors++; $display("FAIL drain_pc i=%0d got %h want %h", i, bus.dec_pc_o, exp_pc); end
            cycle(0, 32'h0, 32'h0, 0, 1);
        end
        vectors += 2;
        if (bus.dec_valid_o !== 1'b0) begin errors++; $display("FAIL drain_empty got %0b want 0", bus.dec_valid_o); end
        if (bus.overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b want 1", bus.overflow_o); end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] exp_pc;
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1, 32'h00000013, 32'(i * 4), 0, 0);
        cycle(1, 32'h00000013, 32'h10, 0, 1);
        vectors += 3;
        if (bus.count_o !== 3'd4) begin errors++; $display("FAIL fpp_count got %0d want 4", bus.count_o); end
        if (bus.overflow_o !== 1'b0) begin errors++; $display("FAIL fpp_ovf got %0b want 0", bus.overflow_o); end
        if (bus.dec_pc_o !== 32'h4) begin errors++; $display("FAIL fpp_head got %h want 4", bus.dec_pc_o); end
        // Head after k further stream cycles is the pc pushed k+1 slots after 0x4.
        for (int k = 0; k < 12; k++) begin
            cycle(1, 32'h00000013, 32'h14 + 32'(k * 4), 0, 1);
            exp_pc = 32'h8 + 32'(k * 4);
            vectors++;
            if (bus.dec_pc_o !== exp_pc || bus.count_o !== 3'd4) begin
                errors++;
                $display("FAIL wrap_stream k=%0d got pc %h cnt %0d want pc %h cnt 4", k, bus.dec_pc_o, bus.count_o, exp_pc);
            end
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1, 32'h00000013, 32'(i * 4), 0, 0);
        cycle(1, 32'h00000013, 32'h40, 1, 1);
        vectors += 2;
        if (bus.count_o !== 3'd0) begin errors++; $display("FAIL flush_count got %0d want 0", bus.count_o); end
        if (bus.dec_valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b want 0", bus.dec_valid_o); end
        cycle(1, 32'h00000013, 32'h80, 0, 0);
        vectors += 2;
        if (bus.dec_pc_o !== 32'h80) begin errors++; $display("FAIL flush_head got %h want 80", bus.dec_pc_o); end
        if (bus.count_o !== 3'd1) begin errors++; $display("FAIL flush_refill got %0d want 1", bus.count_o); end
    endtask

    task automatic test_illegal_async_reset();
        do_reset();
        cycle(1, 32'h00004501, 32'h100, 0, 0);
        vectors++;
        if (bus.dec_illegal_o !== 1'b1) begin errors++; $display("FAIL illegal_flag got %0b want 1", bus.dec_illegal_o); end
        cycle(1, 32'h00000013, 32'h102, 0, 0);
        vectors++;
        if (bus.count_o !== 3'd2) begin errors++; $display("FAIL pre_arst_count got %0d want 2", bus.count_o); end
        #2 arst = 1'b1;
        #1;
        vectors += 2;
        if (bus.dec_valid_o !== 1'b0) begin errors++; $display("FAIL arst_valid got %0b want 0", bus.dec_valid_o); end
        if (bus.count_o !== 3'd0) begin errors++; $display("FAIL arst_count got %0d want 0", bus.count_o); end
        #1 arst = 1'b0;
        model_q.delete();
        model_ovf = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        bit          e_valid;
        bit          e_ill;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom % 4) != 0, $urandom, $urandom, ($urandom % 20) == 0, ($urandom % 3) != 0);
            e_valid = model_q.size() != 0;
            e_instr = e_valid ? model_q[0][63:32] : 32'h0;
            e_pc    = e_valid ? model_q[0][31:0]  : 32'h0;
            e_ill   = e_valid && (e_instr[1:0] != 2'b11);
            vectors++;
            if (bus.dec_valid_o !== e_valid || bus.dec_instr_o !== e_instr || bus.dec_pc_o !== e_pc ||
                bus.dec_illegal_o !== e_ill || bus.count_o !== 3'(model_q.size()) ||
                bus.fetch_stall_o !== (model_q.size() >= DEPTH - SKID) || bus.overflow_o !== model_ovf) begin
                errors++;
                $display("FAIL random n=%0d got v%0b i%h p%h il%0b c%0d s%0b o%0b want v%0b i%h p%h il%0b c%0d o%0b",
                         n, bus.dec_valid_o, bus.dec_instr_o, bus.dec_pc_o, bus.dec_illegal_o, bus.count_o,
                         bus.fetch_stall_o, bus.overflow_o, e_valid, e_instr, e_pc, e_ill, model_q.size(), model_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_stall();
        test_full_push_pop();
        test_flush();
        test_illegal_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
